// File: rtl/bp_cce_pkg.sv
// -----------------------------------------------------------------------------
// bp_cce_pkg
// Shared CCE types: coherence states, directory minor ops, GPR operand ids,
// plus the directory request controller state type and response record.
// -----------------------------------------------------------------------------
package bp_cce_pkg;

    typedef enum logic [2:0] {
        e_COH_I = 3'b000,
        e_COH_S = 3'b001,
        e_COH_E = 3'b010,
        e_COH_F = 3'b011,
        e_COH_M = 3'b110,
        e_COH_O = 3'b111
    } bp_coh_states_e;

    typedef enum logic [3:0] {
        e_rdp_op = 4'b0000,
        e_rdw_op = 4'b0001,
        e_rde_op = 4'b0010,
        e_wdp_op = 4'b0011,
        e_clr_op = 4'b0100,
        e_wde_op = 4'b0101,
        e_wds_op = 4'b0110,
        e_gad_op = 4'b0111
    } bp_cce_inst_minor_dir_op_e;

    typedef enum logic [3:0] {
        e_opd_r0 = 4'b0000,
        e_opd_r1 = 4'b0001,
        e_opd_r2 = 4'b0010,
        e_opd_r3 = 4'b0011,
        e_opd_r4 = 4'b0100,
        e_opd_r5 = 4'b0101,
        e_opd_r6 = 4'b0110,
        e_opd_r7 = 4'b0111
    } bp_cce_inst_opd_gpr_e;

    typedef enum logic [1:0] {
        e_dir_req_ready,
        e_dir_req_issue,
        e_dir_req_wait,
        e_dir_req_resp
    } bp_cce_dir_req_state_e;

    // Field widths of the response record for the default configuration.
    localparam int unsigned dir_resp_paddr_width_lp = 40;
    localparam int unsigned dir_resp_num_lce_lp     = 8;
    localparam int unsigned dir_resp_assoc_width_lp = 3;

    typedef struct packed {
        logic [dir_resp_num_lce_lp-1:0]                           sharers_hits;
        logic [dir_resp_num_lce_lp*dir_resp_assoc_width_lp-1:0]   sharers_ways;
        logic [dir_resp_num_lce_lp*$bits(bp_coh_states_e)-1:0]    sharers_coh_states;
        logic                                                     lru_v;
        logic                                                     lru_cached_excl;
        logic [dir_resp_paddr_width_lp-1:0]                       lru_addr;
        logic [dir_resp_paddr_width_lp-1:0]                       addr;
        bp_cce_inst_opd_gpr_e                                     gpr;
        logic                                                     err;
    } bp_cce_dir_resp_s;

    // Read ops wait for directory results; every other op is a fire-and-forget write.
    function automatic logic dir_op_is_read(input bp_cce_inst_minor_dir_op_e op);
        return (op == e_rdw_op) || (op == e_rde_op);
    endfunction

endpackage

// File: rtl/bp_cce_dir_resp_capture.sv
// -----------------------------------------------------------------------------
// bp_cce_dir_resp_capture
// Capture registers for directory read results. While en_i is high each
// result group is loaded in the cycle its valid is high; clear_i empties all
// groups at the start of a new operation. Contents double as the response.
// Ports:
//   clk_i, reset_i           clock, async active-low reset
//   clear_i                  empty all groups (new operation accepted)
//   en_i                     capture window (controller in WAIT)
//   sharers_*_i / lru_*_i / addr_* / gpr_i   directory result inputs
//   *_o                      captured values
//   sharers_seen_o, addr_seen_o   group captured in an earlier cycle
// -----------------------------------------------------------------------------
module bp_cce_dir_resp_capture
    import bp_cce_pkg::*;
#(
    parameter int unsigned paddr_width_p     = 40,
    parameter int unsigned lce_assoc_width_p = 3,
    parameter int unsigned num_lce_p         = 8
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic                                          clear_i,
    input  logic                                          en_i,
    input  logic                                          sharers_v_i,
    input  logic [num_lce_p-1:0]                          sharers_hits_i,
    input  logic [num_lce_p*lce_assoc_width_p-1:0]        sharers_ways_i,
    input  logic [num_lce_p*$bits(bp_coh_states_e)-1:0]   sharers_coh_states_i,
    input  logic                                          lru_v_i,
    input  logic                                          lru_cached_excl_i,
    input  logic [paddr_width_p-1:0]                      lru_addr_i,
    input  logic                                          addr_v_i,
    input  logic [paddr_width_p-1:0]                      addr_i,
    input  bp_cce_inst_opd_gpr_e                          gpr_i,
    output logic [num_lce_p-1:0]                          sharers_hits_o,
    output logic [num_lce_p*lce_assoc_width_p-1:0]        sharers_ways_o,
    output logic [num_lce_p*$bits(bp_coh_states_e)-1:0]   sharers_coh_states_o,
    output logic                                          lru_v_o,
    output logic                                          lru_cached_excl_o,
    output logic [paddr_width_p-1:0]                      lru_addr_o,
    output logic [paddr_width_p-1:0]                      addr_o,
    output bp_cce_inst_opd_gpr_e                          gpr_o,
    output logic                                          sharers_seen_o,
    output logic                                          addr_seen_o
);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sharers_hits_o       <= '0;
            sharers_ways_o       <= '0;
            sharers_coh_states_o <= '0;
            sharers_seen_o       <= 1'b0;
            lru_v_o              <= 1'b0;
            lru_cached_excl_o    <= 1'b0;
            lru_addr_o           <= '0;
            addr_o               <= '0;
            gpr_o                <= e_opd_r0;
            addr_seen_o          <= 1'b0;
        end else if (clear_i) begin
            sharers_hits_o       <= '0;
            sharers_ways_o       <= '0;
            sharers_coh_states_o <= '0;
            sharers_seen_o       <= 1'b0;
            lru_v_o              <= 1'b0;
            lru_cached_excl_o    <= 1'b0;
            lru_addr_o           <= '0;
            addr_o               <= '0;
            gpr_o                <= e_opd_r0;
            addr_seen_o          <= 1'b0;
        end else if (en_i) begin
            if (sharers_v_i) begin
                sharers_hits_o       <= sharers_hits_i;
                sharers_ways_o       <= sharers_ways_i;
                sharers_coh_states_o <= sharers_coh_states_i;
                sharers_seen_o       <= 1'b1;
            end
            if (lru_v_i) begin
                lru_v_o           <= 1'b1;
                lru_cached_excl_o <= lru_cached_excl_i;
                lru_addr_o        <= lru_addr_i;
            end
            if (addr_v_i) begin
                addr_o      <= addr_i;
                gpr_o       <= gpr_i;
                addr_seen_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_cce_dir_req_ctrl.sv
// -----------------------------------------------------------------------------
// bp_cce_dir_req_ctrl
// Request-side controller for the CCE coherence directory. Takes one
// directory op at a time (req valid/ready), issues it with a single-cycle
// read or write strobe once the directory is not busy, collects read results
// and returns them registered (resp valid/yumi). A WAIT-phase timeout
// reports a directory that never answers via resp_err_o.
// Ports:
//   clk_i, reset_i                 clock, async active-low reset
//   req_*                          incoming op and its operands
//   dir_*_o                        registered op/operands and strobes to directory
//   dir_busy_i, dir_*_v_i, ...     directory status and results
//   resp_*                         captured results, error flag, handshake
// -----------------------------------------------------------------------------
module bp_cce_dir_req_ctrl
    import bp_cce_pkg::*;
#(
    parameter int unsigned paddr_width_p     = 40,
    parameter int unsigned lce_id_width_p    = 4,
    parameter int unsigned lce_assoc_width_p = 3,
    parameter int unsigned num_lce_p         = 8,
    parameter int unsigned timeout_p         = 64
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,

    input  logic                                          req_v_i,
    output logic                                          req_ready_o,
    input  bp_cce_inst_minor_dir_op_e                     req_cmd_i,
    input  logic [paddr_width_p-1:0]                      req_addr_i,
    input  logic                                          req_addr_bypass_i,
    input  logic [lce_id_width_p-1:0]                     req_lce_i,
    input  logic [lce_assoc_width_p-1:0]                  req_way_i,
    input  logic [lce_assoc_width_p-1:0]                  req_lru_way_i,
    input  bp_coh_states_e                                req_coh_state_i,
    input  bp_cce_inst_opd_gpr_e                          req_gpr_i,

    output logic [paddr_width_p-1:0]                      dir_addr_o,
    output logic                                          dir_addr_bypass_o,
    output logic [lce_id_width_p-1:0]                     dir_lce_o,
    output logic [lce_assoc_width_p-1:0]                  dir_way_o,
    output logic [lce_assoc_width_p-1:0]                  dir_lru_way_o,
    output bp_coh_states_e                                dir_coh_state_o,
    output bp_cce_inst_opd_gpr_e                          dir_addr_dst_gpr_o,
    output bp_cce_inst_minor_dir_op_e                     dir_cmd_o,
    output logic                                          dir_r_v_o,
    output logic                                          dir_w_v_o,

    input  logic                                          dir_busy_i,
    input  logic                                          dir_sharers_v_i,
    input  logic [num_lce_p-1:0]                          dir_sharers_hits_i,
    input  logic [num_lce_p*lce_assoc_width_p-1:0]        dir_sharers_ways_i,
    input  logic [num_lce_p*$bits(bp_coh_states_e)-1:0]   dir_sharers_coh_states_i,
    input  logic                                          dir_lru_v_i,
    input  logic                                          dir_lru_cached_excl_i,
    input  logic [paddr_width_p-1:0]                      dir_lru_addr_i,
    input  logic                                          dir_addr_v_i,
    input  logic [paddr_width_p-1:0]                      dir_addr_i,
    input  bp_cce_inst_opd_gpr_e                          dir_addr_dst_gpr_i,

    output logic                                          resp_v_o,
    input  logic                                          resp_yumi_i,
    output logic [num_lce_p-1:0]                          resp_sharers_hits_o,
    output logic [num_lce_p*lce_assoc_width_p-1:0]        resp_sharers_ways_o,
    output logic [num_lce_p*$bits(bp_coh_states_e)-1:0]   resp_sharers_coh_states_o,
    output logic                                          resp_lru_v_o,
    output logic                                          resp_lru_cached_excl_o,
    output logic [paddr_width_p-1:0]                      resp_lru_addr_o,
    output logic [paddr_width_p-1:0]                      resp_addr_o,
    output bp_cce_inst_opd_gpr_e                          resp_gpr_o,
    output logic                                          resp_err_o
);

    localparam int unsigned cnt_width_lp = $clog2(timeout_p);
    localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(timeout_p - 1);

    bp_cce_dir_req_state_e state_r, state_n;
    logic [cnt_width_lp-1:0] cnt_r;
    logic accept, done, timeout, in_wait;
    logic sharers_seen, addr_seen;

    assign in_wait = (state_r == e_dir_req_wait);

    // Completion may use a result arriving in the same cycle as well as one
    // captured earlier, so the minimum read latency stays at three cycles.
    always_comb begin
        done = 1'b0;
        if (!dir_busy_i) begin
            if (dir_cmd_o == e_rdw_op)
                done = sharers_seen | dir_sharers_v_i;
            else if (dir_cmd_o == e_rde_op)
                done = addr_seen | dir_addr_v_i;
        end
    end

    assign timeout = (cnt_r == cnt_max_lp);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)
            state_r <= e_dir_req_ready;
        else
            state_r <= state_n;
    end

    always_comb begin
        state_n     = state_r;
        accept      = 1'b0;
        req_ready_o = 1'b0;
        dir_r_v_o   = 1'b0;
        dir_w_v_o   = 1'b0;
        resp_v_o    = 1'b0;
        case (state_r)
            e_dir_req_ready: begin
                // Gated by reset so every output reads zero while reset is held.
                req_ready_o = reset_i;
                if (req_v_i) begin
                    accept  = 1'b1;
                    state_n = e_dir_req_issue;
                end
            end
            e_dir_req_issue: begin
                if (!dir_busy_i) begin
                    if (dir_op_is_read(dir_cmd_o)) begin
                        dir_r_v_o = 1'b1;
                        state_n   = e_dir_req_wait;
                    end else begin
                        dir_w_v_o = 1'b1;
                        state_n   = e_dir_req_ready;
                    end
                end
            end
            e_dir_req_wait: begin
                if (done || timeout)
                    state_n = e_dir_req_resp;
            end
            e_dir_req_resp: begin
                resp_v_o = 1'b1;
                if (resp_yumi_i)
                    state_n = e_dir_req_ready;
            end
            default: state_n = e_dir_req_ready;
        endcase
    end

    // Operand registers presented to the directory.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            dir_addr_o         <= '0;
            dir_addr_bypass_o  <= 1'b0;
            dir_lce_o          <= '0;
            dir_way_o          <= '0;
            dir_lru_way_o      <= '0;
            dir_coh_state_o    <= e_COH_I;
            dir_addr_dst_gpr_o <= e_opd_r0;
            dir_cmd_o          <= e_rdp_op;
        end else if (accept) begin
            dir_addr_o         <= req_addr_i;
            dir_addr_bypass_o  <= req_addr_bypass_i;
            dir_lce_o          <= req_lce_i;
            dir_way_o          <= req_way_i;
            dir_lru_way_o      <= req_lru_way_i;
            dir_coh_state_o    <= req_coh_state_i;
            dir_addr_dst_gpr_o <= req_gpr_i;
            dir_cmd_o          <= req_cmd_i;
        end
    end

    // WAIT cycle counter; saturates instead of wrapping.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)
            cnt_r <= '0;
        else if (accept)
            cnt_r <= '0;
        else if (in_wait && !timeout)
            cnt_r <= cnt_r + cnt_width_lp'(1);
    end

    // Error flag: set only when WAIT ends without completion.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)
            resp_err_o <= 1'b0;
        else if (accept)
            resp_err_o <= 1'b0;
        else if (in_wait && (done || timeout))
            resp_err_o <= ~done;
    end

    bp_cce_dir_resp_capture #(
        .paddr_width_p     (paddr_width_p),
        .lce_assoc_width_p (lce_assoc_width_p),
        .num_lce_p         (num_lce_p)
    ) capture (
        .clk_i                (clk_i),
        .reset_i              (reset_i),
        .clear_i              (accept),
        .en_i                 (in_wait),
        .sharers_v_i          (dir_sharers_v_i),
        .sharers_hits_i       (dir_sharers_hits_i),
        .sharers_ways_i       (dir_sharers_ways_i),
        .sharers_coh_states_i (dir_sharers_coh_states_i),
        .lru_v_i              (dir_lru_v_i),
        .lru_cached_excl_i    (dir_lru_cached_excl_i),
        .lru_addr_i           (dir_lru_addr_i),
        .addr_v_i             (dir_addr_v_i),
        .addr_i               (dir_addr_i),
        .gpr_i                (dir_addr_dst_gpr_i),
        .sharers_hits_o       (resp_sharers_hits_o),
        .sharers_ways_o       (resp_sharers_ways_o),
        .sharers_coh_states_o (resp_sharers_coh_states_o),
        .lru_v_o              (resp_lru_v_o),
        .lru_cached_excl_o    (resp_lru_cached_excl_o),
        .lru_addr_o           (resp_lru_addr_o),
        .addr_o               (resp_addr_o),
        .gpr_o                (resp_gpr_o),
        .sharers_seen_o       (sharers_seen),
        .addr_seen_o          (addr_seen)
    );

`ifndef SYNTHESIS
    strobes_exclusive: assert property (@(posedge clk_i) disable iff (!reset_i)
        !(dir_r_v_o && dir_w_v_o));
    no_strobe_when_busy: assert property (@(posedge clk_i) disable iff (!reset_i)
        !((dir_r_v_o || dir_w_v_o) && dir_busy_i));
`endif

endmodule

// File: doc/bp_cce_dir_req_ctrl.md
Name: bp_cce_dir_req_ctrl

Overview:
- Request-side controller for the CCE coherence directory. It drives the directory's command port (r_v, w_v, cmd, addr, lce, way, lru_way, coh_state, addr_dst_gpr) and collects its result outputs.
- Accepts one directory operation at a time from the CCE microcode datapath over a valid/ready handshake, issues it once the directory is not busy, and waits for the read results (sharers, LRU, addr).
- Returns a registered response over a valid/yumi handshake. A timeout flags a directory that never answers.

Parameters:
- paddr_width_p, 40, physical address width
- lce_id_width_p, 4, LCE id width
- lce_assoc_width_p, 3, way index width
- num_lce_p, 8, number of LCEs tracked (sharers vector width)
- timeout_p, 64, max cycles in WAIT before error; minimum 2

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-low
- req_v_i  in  1  request valid
- req_ready_o  out  1  controller can accept a request
- req_cmd_i  in  $bits(bp_cce_inst_minor_dir_op_e)  directory op
- req_addr_i  in  paddr_width_p  address
- req_addr_bypass_i  in  1  address bypass
- req_lce_i  in  lce_id_width_p  LCE id
- req_way_i  in  lce_assoc_width_p  way
- req_lru_way_i  in  lce_assoc_width_p  LRU way
- req_coh_state_i  in  $bits(bp_coh_states_e)  write state
- req_gpr_i  in  $bits(bp_cce_inst_opd_gpr_e)  addr destination GPR
- dir_*_o  out  same widths as req_*  registered copies to directory (addr, addr_bypass, lce, way, lru_way, coh_state, addr_dst_gpr, cmd)
- dir_r_v_o / dir_w_v_o  out  1 each  single-cycle read/write strobes
- dir_busy_i, dir_sharers_v_i, dir_lru_v_i, dir_lru_cached_excl_i, dir_addr_v_i  in  1 each  directory status
- dir_sharers_hits_i  in  num_lce_p;  dir_sharers_ways_i  in  num_lce_p*lce_assoc_width_p;  dir_sharers_coh_states_i  in  num_lce_p*$bits(bp_coh_states_e)
- dir_lru_addr_i, dir_addr_i  in  paddr_width_p;  dir_addr_dst_gpr_i  in  $bits(bp_cce_inst_opd_gpr_e)
- resp_v_o  out  1  response valid;  resp_yumi_i  in  1  response consumed
- resp_sharers_hits_o/ways_o/coh_states_o, resp_lru_v_o, resp_lru_cached_excl_o, resp_lru_addr_o, resp_addr_o, resp_gpr_o  out  captured results
- resp_err_o  out  1  timeout occurred

Behaviour:
- Reset (asynchronous, active-low): state=READY, all outputs and registers 0, gpr fields e_opd_r0, coh fields e_COH_I. A reset assertion mid-operation drops dir_r_v_o/dir_w_v_o immediately and discards the operation.
- READY: req_ready_o=1. On req_v_i, latch all req_* into dir_*_o registers, clear the capture registers and timeout counter, go to ISSUE.
- ISSUE: if dir_busy_i, hold with strobes low. Otherwise assert exactly one strobe for one cycle.
  - e_rdw_op or e_rde_op: dir_r_v_o; next state WAIT.
  - Any other op: dir_w_v_o; next state READY, no response.
- WAIT: capture each result group in the cycle its valid is high.
  - sharers_v captures hits/ways/states.
  - lru_v captures lru_v=1, cached_excl, lru_addr.
  - addr_v captures addr and gpr.
  - Completion for RDW: sharers captured (this cycle or earlier) and dir_busy_i low.
  - Completion for RDE: addr captured and dir_busy_i low.
  - On completion go to RESP with err=0.
  - Counter increments each WAIT cycle. If it reaches timeout_p-1 without completion, go to RESP with err=1, keeping whatever has been captured.
  - Simultaneous completion and timeout in the same cycle: completion wins, err=0.
- RESP: resp_v_o=1 and resp_* held stable until resp_yumi_i, then READY. req_ready_o is low in ISSUE, WAIT and RESP.
- Minimum read latency (directory idle, results returned the cycle after the strobe): request accepted at cycle 0, strobe at cycle 1, resp_v_o at cycle 3.
- Throughput: one operation in flight; writes take 2 cycles, READY to READY.
- Counter width is clog2(timeout_p); it does not wrap.
- Assertions (nonsynth): dir_r_v_o and dir_w_v_o never high together; no strobe while dir_busy_i is high.

Decomposition:
- bp_cce_pkg: add enum bp_cce_dir_req_state_e {e_dir_req_ready, e_dir_req_issue, e_dir_req_wait, e_dir_req_resp}.
- bp_cce_pkg: add a packed struct bp_cce_dir_resp_s holding the response fields.
- Reuse bp_coh_states_e, bp_cce_inst_minor_dir_op_e and bp_cce_inst_opd_gpr_e unchanged.
- Natural sub-module: bp_cce_dir_resp_capture, the WAIT-phase capture registers with per-group valid flags.

Test Plan:
- RDW, dir idle, sharers_v and lru_v=1 with lru_addr=0x8000_0040 one cycle after strobe, hits=8'b0000_0101 -> resp_v_o at cycle 3; hits=0x05, lru_addr=0x8000_0040, err=0.
- WDS with dir_busy_i held high 5 cycles -> dir_w_v_o pulses exactly once, on the first cycle busy is low; req_ready_o high the next cycle; resp_v_o never asserted.
- RDE, addr_v with addr=0x1234_5000 and gpr=e_opd_r3 arriving 4 cycles after strobe while busy stays high 2 more cycles -> response only after busy drops; addr=0x1234_5000, gpr=e_opd_r3.
- RDW with no sharers_v ever, timeout_p=8 -> resp_v_o after 8 WAIT cycles, err=1, hits=0.
- Response held with resp_yumi_i low 10 cycles while a new req_v_i arrives -> req_ready_o=0 and fields stable; yumi accepts, then the request is taken in READY.
- Reset driven low during WAIT -> all outputs 0 asynchronously; after release state READY, req_ready_o=1, no stale response.
